// File: rtl/float_cmp_pkg.sv
// Shared definitions for the IEEE-754 comparator: predicate encodings,
// operand class bits and word-width derivation.
package float_cmp_pkg;

    typedef enum logic [2:0] {
        OP_EQ    = 3'd0,
        OP_NE    = 3'd1,
        OP_LT    = 3'd2,
        OP_LE    = 3'd3,
        OP_GT    = 3'd4,
        OP_GE    = 3'd5,
        OP_UNORD = 3'd6,
        OP_ORD   = 3'd7
    } op_e;

    localparam int unsigned CLS_NAN  = 0;
    localparam int unsigned CLS_SNAN = 1;
    localparam int unsigned CLS_ZERO = 2;
    localparam int unsigned CLS_W    = 3;

    typedef logic [CLS_W-1:0] cls_t;

    function automatic int unsigned word_w(input int unsigned exp_w, input int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

endpackage

// File: rtl/float_cmp_if.sv
// Operand/result handshake bundle for float_cmp; master drives operands
// and accepts results, slave is the comparator.
interface float_cmp_if
    import float_cmp_pkg::*;
#(
    parameter int unsigned EXP_W = 11,
    parameter int unsigned MAN_W = 52
);
    localparam int unsigned W = word_w(EXP_W, MAN_W);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic         z;
    logic         unordered;
    logic         invalid;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, z, unordered, invalid
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, z, unordered, invalid
    );

endinterface

// File: rtl/float_classify.sv
// Combinational NaN / signalling-NaN / zero decode of an unsigned
// (sign-stripped) IEEE-754 magnitude.
module float_classify
    import float_cmp_pkg::*;
#(
    parameter int unsigned EXP_W = 11,
    parameter int unsigned MAN_W = 52
) (
    input  logic [EXP_W+MAN_W-1:0] x_i,
    output cls_t                   cls_o
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             is_nan;

    assign exp_f  = x_i[EXP_W+MAN_W-1:MAN_W];
    assign man_f  = x_i[MAN_W-1:0];
    assign is_nan = (&exp_f) & (|man_f);

    always_comb begin
        cls_o           = '0;
        cls_o[CLS_NAN]  = is_nan;
        // Quiet bit is the mantissa MSB; clear means signalling.
        cls_o[CLS_SNAN] = is_nan & ~man_f[MAN_W-1];
        cls_o[CLS_ZERO] = ~(|exp_f) & ~(|man_f);
    end

endmodule

// File: rtl/float_cmp.sv
// Two-stage pipelined IEEE-754 comparator with per-transaction predicate,
// unordered/invalid flags and valid/ready flow control.
module float_cmp
    import float_cmp_pkg::*;
#(
    parameter int unsigned EXP_W = 11,
    parameter int unsigned MAN_W = 52
) (
    input logic       clk,
    input logic       rst_n,
    float_cmp_if.slave bus
);

    localparam int unsigned W = word_w(EXP_W, MAN_W);

    logic s1_v_q, s2_v_q;
    logic s1_en, s2_en;

    assign s2_en        = ~s2_v_q | bus.out_ready;
    assign s1_en        = ~s1_v_q | s2_en;
    assign bus.in_ready = s1_en;

    cls_t cls_a_d, cls_b_d;
    cls_t cls_a_q, cls_b_q;
    logic sa_q, sb_q, mag_lt_q, mag_eq_q;
    op_e  op_q;

    float_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .x_i  (bus.a[W-2:0]),
        .cls_o(cls_a_d)
    );

    float_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .x_i  (bus.b[W-2:0]),
        .cls_o(cls_b_d)
    );

    always_ff @(posedge clk) begin
        if (s1_en) begin
            cls_a_q  <= cls_a_d;
            cls_b_q  <= cls_b_d;
            sa_q     <= bus.a[W-1];
            sb_q     <= bus.b[W-1];
            mag_lt_q <= bus.a[W-2:0] <  bus.b[W-2:0];
            mag_eq_q <= bus.a[W-2:0] == bus.b[W-2:0];
            op_q     <= op_e'(bus.op);
        end
    end

    logic un, eq, lt, sig_pred;
    logic z_d, inv_d;
    logic z_q, un_q, inv_q;

    always_comb begin
        un = cls_a_q[CLS_NAN] | cls_b_q[CLS_NAN];
        eq = (cls_a_q[CLS_ZERO] & cls_b_q[CLS_ZERO]) | ((sa_q == sb_q) & mag_eq_q);
        if (sa_q != sb_q)
            lt = sa_q;
        else if (!sa_q)
            lt = mag_lt_q;
        else
            lt = ~mag_lt_q & ~mag_eq_q;
        lt = lt & ~eq;

        sig_pred = (op_q == OP_LT) | (op_q == OP_LE) | (op_q == OP_GT) | (op_q == OP_GE);

        z_d = 1'b0;
        if (un) begin
            z_d = (op_q == OP_NE) | (op_q == OP_UNORD);
        end else begin
            case (op_q)
                OP_EQ:    z_d = eq;
                OP_NE:    z_d = ~eq;
                OP_LT:    z_d = lt;
                OP_LE:    z_d = lt | eq;
                OP_GT:    z_d = ~lt & ~eq;
                OP_GE:    z_d = ~lt;
                OP_UNORD: z_d = 1'b0;
                OP_ORD:   z_d = 1'b1;
                default:  z_d = 1'b0;
            endcase
        end

        inv_d = cls_a_q[CLS_SNAN] | cls_b_q[CLS_SNAN] | (un & sig_pred);
    end

    // Result and flags are qualified by s1_v so bubbles present all-zero outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            z_q    <= 1'b0;
            un_q   <= 1'b0;
            inv_q  <= 1'b0;
        end else begin
            if (s1_en)
                s1_v_q <= bus.in_valid;
            if (s2_en) begin
                s2_v_q <= s1_v_q;
                z_q    <= s1_v_q & z_d;
                un_q   <= s1_v_q & un;
                inv_q  <= s1_v_q & inv_d;
            end
        end
    end

    assign bus.out_valid = s2_v_q;
    assign bus.z         = z_q;
    assign bus.unordered = un_q;
    assign bus.invalid   = inv_q;

endmodule

// File: tb/tb_float_cmp.sv
// Scoreboard bench for float_cmp: directed vectors push expectations,
// independent monitors pop and compare on each output transfer.
module tb_float_cmp;
    import float_cmp_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    float_cmp_if #(.EXP_W(11), .MAN_W(52)) bus64 ();
    float_cmp_if #(.EXP_W(8),  .MAN_W(23)) bus32 ();

    float_cmp #(.EXP_W(11), .MAN_W(52)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
    float_cmp #(.EXP_W(8),  .MAN_W(23)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    typedef struct {
        string name;
        logic  ez;
        logic  eun;
        logic  einv;
        int    lat_c;
    } exp_t;

    exp_t q64[$];
    exp_t q32[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, want);
        end
    endtask

    // ---------------- monitors ----------------
    logic       held64 = 1'b0;
    logic [2:0] held_v;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held64 = 1'b0;
        end else begin
            if (held64)
                chk("hold64", 64'({bus64.out_valid, bus64.z, bus64.unordered, bus64.invalid}),
                    64'({1'b1, held_v}));
            if (bus64.out_valid) begin
                if (bus64.out_ready) begin
                    held64 = 1'b0;
                    if (q64.size() == 0) begin
                        chk("unexpected64", 64'(bus64.out_valid), 64'(0));
                    end else begin
                        e = q64.pop_front();
                        chk(e.name, 64'({bus64.z, bus64.unordered, bus64.invalid}),
                            64'({e.ez, e.eun, e.einv}));
                        if (e.lat_c >= 0)
                            chk({e.name, " latency"}, 64'(cyc - e.lat_c), 64'(2));
                    end
                end else begin
                    held64 = 1'b1;
                    held_v = {bus64.z, bus64.unordered, bus64.invalid};
                end
            end else begin
                held64 = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus32.out_valid) begin
            if (q32.size() == 0) begin
                chk("unexpected32", 64'(bus32.out_valid), 64'(0));
            end else begin
                e = q32.pop_front();
                chk(e.name, 64'({bus32.z, bus32.unordered, bus32.invalid}),
                    64'({e.ez, e.eun, e.einv}));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send64(input string nm, input logic [63:0] a, input logic [63:0] b,
                          input logic [2:0] op, input logic ez, input logic eun,
                          input logic einv, input bit lat);
        bit rdy;
        int c;
        @(negedge clk);
        bus64.in_valid = 1'b1;
        bus64.a = a;
        bus64.b = b;
        bus64.op = op;
        for (int i = 0; i < 300; i++) begin
            #1;
            rdy = bus64.in_ready;
            c   = cyc;
            @(posedge clk);
            if (rdy) begin
                q64.push_back('{name: nm, ez: ez, eun: eun, einv: einv, lat_c: (lat ? c : -1)});
                n_acc++;
                return;
            end
            @(negedge clk);
        end
        chk({nm, " accept timeout"}, 64'(0), 64'(1));
    endtask

    task automatic idle64();
        @(negedge clk);
        bus64.in_valid = 1'b0;
    endtask

    task automatic send32(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic ez, input logic eun, input logic einv);
        bit rdy;
        @(negedge clk);
        bus32.in_valid = 1'b1;
        bus32.a = a;
        bus32.b = b;
        bus32.op = op;
        for (int i = 0; i < 300; i++) begin
            #1;
            rdy = bus32.in_ready;
            @(posedge clk);
            if (rdy) begin
                q32.push_back('{name: nm, ez: ez, eun: eun, einv: einv, lat_c: -1});
                @(negedge clk);
                bus32.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk({nm, " accept timeout"}, 64'(0), 64'(1));
    endtask

    task automatic set_ready64(input logic r);
        @(posedge clk);
        #1 bus64.out_ready = r;
    endtask

    localparam logic [63:0] ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] TWO  = 64'h4000000000000000;
    localparam logic [63:0] QNAN = 64'h7FF8000000000000;
    localparam logic [63:0] SNAN = 64'h7FF0000000000001;

    initial begin
        bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0; bus64.op = '0; bus64.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.op = '0; bus32.out_ready = 1'b1;

        #2;
        chk("reset out_valid", 64'(bus64.out_valid), 64'(0));
        chk("reset z/flags", 64'({bus64.z, bus64.unordered, bus64.invalid}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset in_ready", 64'(bus64.in_ready), 64'(1));

        // main function, latency checked on the first pair
        send64("1<2 LT",  ONE, TWO, OP_LT, 1'b1, 1'b0, 1'b0, 1'b1);
        send64("1<2 GE",  ONE, TWO, OP_GE, 1'b0, 1'b0, 1'b0, 1'b1);
        send64("+0=-0 EQ", 64'h0, 64'h8000000000000000, OP_EQ, 1'b1, 1'b0, 1'b0, 1'b0);
        send64("+0,-0 LT", 64'h0, 64'h8000000000000000, OP_LT, 1'b0, 1'b0, 1'b0, 1'b0);
        send64("-0,+0 LE", 64'h8000000000000000, 64'h0, OP_LE, 1'b1, 1'b0, 1'b0, 1'b0);
        send64("qNaN NE",  QNAN, ONE, OP_NE, 1'b1, 1'b1, 1'b0, 1'b0);
        send64("qNaN LT",  QNAN, ONE, OP_LT, 1'b0, 1'b1, 1'b1, 1'b0);
        send64("sNaN EQ",  SNAN, ONE, OP_EQ, 1'b0, 1'b1, 1'b1, 1'b0);
        send64("qNaN UNORD", ONE, QNAN, OP_UNORD, 1'b1, 1'b1, 1'b0, 1'b0);
        send64("qNaN ORD", ONE, QNAN, OP_ORD, 1'b0, 1'b1, 1'b0, 1'b0);
        send64("sNaN ORD", ONE, SNAN, OP_ORD, 1'b0, 1'b1, 1'b1, 1'b0);
        send64("-2<-1 LT", 64'hC000000000000000, 64'hBFF0000000000000, OP_LT, 1'b1, 1'b0, 1'b0, 1'b0);
        send64("-1<+1 LT", 64'hBFF0000000000000, ONE, OP_LT, 1'b1, 1'b0, 1'b0, 1'b0);
        send64("inf>max GT", 64'h7FF0000000000000, 64'h7FEFFFFFFFFFFFFF, OP_GT, 1'b1, 1'b0, 1'b0, 1'b0);
        send64("denorm LT", 64'h1, 64'h2, OP_LT, 1'b1, 1'b0, 1'b0, 1'b0);
        send64("1=1 GE",   ONE, ONE, OP_GE, 1'b1, 1'b0, 1'b0, 1'b0);
        idle64();
        repeat (4) @(negedge clk);

        // backpressure: 4 transactions with the consumer stalled
        set_ready64(1'b0);
        n_acc = 0;
        fork
            begin
                send64("bp0 EQ", ONE, TWO, OP_EQ, 1'b0, 1'b0, 1'b0, 1'b0);
                send64("bp1 NE", ONE, TWO, OP_NE, 1'b1, 1'b0, 1'b0, 1'b0);
                send64("bp2 LE", ONE, TWO, OP_LE, 1'b1, 1'b0, 1'b0, 1'b0);
                send64("bp3 GT", ONE, TWO, OP_GT, 1'b0, 1'b0, 1'b0, 1'b0);
                idle64();
            end
            begin
                repeat (6) @(negedge clk);
                #2;
                chk("bp in_ready", 64'(bus64.in_ready), 64'(0));
                chk("bp accepted", 64'(n_acc), 64'(2));
                set_ready64(1'b1);
            end
        join
        repeat (6) @(negedge clk);

        // asynchronous reset with both stages full
        set_ready64(1'b0);
        send64("rst0", ONE, TWO, OP_LT, 1'b1, 1'b0, 1'b0, 1'b0);
        send64("rst1", ONE, TWO, OP_NE, 1'b1, 1'b0, 1'b0, 1'b0);
        idle64();
        repeat (2) @(negedge clk);
        chk("pre-reset out_valid", 64'(bus64.out_valid), 64'(1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async out_valid", 64'(bus64.out_valid), 64'(0));
        chk("async in_ready", 64'(bus64.in_ready), 64'(1));
        q64.delete();
        @(negedge clk);
        set_ready64(1'b1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) chk("post-reset out_valid", 64'(bus64.out_valid), 64'(0));
        end

        // binary32 instance
        send32("f32 1<=1 LE", 32'h3F800000, 32'h3F800000, OP_LE, 1'b1, 1'b0, 1'b0);
        send32("f32 qNaN UNORD", 32'h7FC00000, 32'h3F800000, OP_UNORD, 1'b1, 1'b1, 1'b0);
        send32("f32 sNaN GT", 32'h7F800001, 32'h3F800000, OP_GT, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 100; i++) begin
            if (q64.size() == 0 && q32.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 64'(q64.size() + q32.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
